// File: rtl/cw_capture_core.sv
// rtl/cw_capture_core.sv - ring-buffer probe capture with mask/edge trigger and valid/ready readout
module cw_capture_core #(
    parameter int DATA_W     = 19,
    parameter int DEPTH      = 4096,
    parameter int INPUT_PIPE = 0,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] probe_data,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic              arm,
    input  logic              abort,
    input  logic              rd_start,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              trig_seen,
    output logic              capture_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE_FILL, S_ARMED, S_POST, S_DONE, S_READ
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, cnt, pre_q, trig_addr, post_len;
    logic              match, match_d, hit;
    logic              wr_en, rd_load, start_cap, trig_fire;

    // Data and trigger share one delay line so the trigger stays aligned with the stored samples.
    generate
        if (INPUT_PIPE == 0) begin : g_nopipe
            assign s = probe_data;
        end else begin : g_pipe
            logic [DATA_W-1:0] pipe [INPUT_PIPE];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < INPUT_PIPE; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= probe_data;
                    for (int i = 1; i < INPUT_PIPE; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign s = pipe[INPUT_PIPE-1];
        end
    endgenerate

    assign match    = ((s ^ trig_value) & trig_mask) == '0;
    assign hit      = trig_edge ? (match & ~match_d) : match;
    assign post_len = {ADDR_W{1'b1}} - pre_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        wr_en     = 1'b0;
        rd_load   = 1'b0;
        start_cap = 1'b0;
        trig_fire = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    start_cap = 1'b1;
                    state_n   = (pre_len == '0) ? S_ARMED : S_PRE_FILL;
                end
            end
            S_PRE_FILL: begin
                wr_en = 1'b1;
                if (cnt == pre_q - ADDR_W'(1)) state_n = S_ARMED;
            end
            S_ARMED: begin
                wr_en = 1'b1;
                if (hit) begin
                    trig_fire = 1'b1;
                    state_n   = (post_len == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                wr_en = 1'b1;
                if (cnt == post_len - ADDR_W'(1)) state_n = S_DONE;
            end
            S_DONE: begin
                if (arm) begin
                    start_cap = 1'b1;
                    state_n   = (pre_len == '0) ? S_ARMED : S_PRE_FILL;
                end else if (rd_start) begin
                    state_n = S_READ;
                end
            end
            S_READ: begin
                if (rd_valid && rd_ready && rd_last) state_n = S_DONE;
                else if (!rd_valid || rd_ready)     rd_load = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            state_n   = S_IDLE;
            wr_en     = 1'b0;
            rd_load   = 1'b0;
            start_cap = 1'b0;
            trig_fire = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr] <= s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            pre_q     <= '0;
            trig_addr <= '0;
            match_d   <= 1'b0;
            trig_seen <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
        end else begin
            match_d <= match;
            if (start_cap) begin
                wr_ptr    <= '0;
                cnt       <= '0;
                pre_q     <= pre_len;
                trig_seen <= 1'b0;
            end
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (wr_en && (state == S_PRE_FILL || state == S_POST))
                cnt <= (state_n == state) ? cnt + ADDR_W'(1) : '0;
            if (trig_fire) begin
                trig_addr <= wr_ptr;
                trig_seen <= 1'b1;
            end
            if (state == S_DONE && state_n == S_READ) rd_ptr <= trig_addr - pre_q;
            // The window is exactly DEPTH entries, so the final beat sits just before the first.
            if (rd_load) begin
                rd_data  <= mem[rd_ptr];
                rd_valid <= 1'b1;
                rd_last  <= (rd_ptr == trig_addr + post_len);
                rd_ptr   <= rd_ptr + ADDR_W'(1);
            end else if (state == S_READ && rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
            if (abort) begin
                rd_valid  <= 1'b0;
                rd_last   <= 1'b0;
                trig_seen <= 1'b0;
            end
        end
    end

    assign busy         = (state == S_PRE_FILL) || (state == S_ARMED) ||
                          (state == S_POST) || (state == S_READ);
    assign capture_done = (state == S_DONE);

endmodule

// File: tb/tb_cw_capture_core.sv
// tb/tb_cw_capture_core.sv - scoreboard bench running INPUT_PIPE=0 and INPUT_PIPE=2 instances side by side
module tb_cw_capture_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] probe_data = '0, trig_mask = '0, trig_value = '0;
    logic       trig_edge = 1'b0;
    logic [3:0] pre_len = '0;
    logic       arm = 1'b0, abort = 1'b0, rd_start = 1'b0, rd_ready = 1'b1;
    logic       rd_valid [2], rd_last [2], busy [2], trig_seen [2], capture_done [2];
    logic [7:0] rd_data [2];

    int compared = 0, mismatched = 0;
    int cyc = 0, arm_at = 0;
    logic [7:0] hist [0:16383];
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    int mode = 0;
    logic [7:0] held_val = '0, cnt_val = '0;
    logic rnd_ready = 1'b0;

    always #5 clk = ~clk;

    cw_capture_core #(.DATA_W(8), .DEPTH(16), .INPUT_PIPE(0)) dut0 (
        .clk(clk), .rst(rst), .probe_data(probe_data), .trig_mask(trig_mask),
        .trig_value(trig_value), .trig_edge(trig_edge), .pre_len(pre_len), .arm(arm),
        .abort(abort), .rd_start(rd_start), .rd_valid(rd_valid[0]), .rd_ready(rd_ready),
        .rd_data(rd_data[0]), .rd_last(rd_last[0]), .busy(busy[0]),
        .trig_seen(trig_seen[0]), .capture_done(capture_done[0]));

    cw_capture_core #(.DATA_W(8), .DEPTH(16), .INPUT_PIPE(2)) dut2 (
        .clk(clk), .rst(rst), .probe_data(probe_data), .trig_mask(trig_mask),
        .trig_value(trig_value), .trig_edge(trig_edge), .pre_len(pre_len), .arm(arm),
        .abort(abort), .rd_start(rd_start), .rd_valid(rd_valid[1]), .rd_ready(rd_ready),
        .rd_data(rd_data[1]), .rd_last(rd_last[1]), .busy(busy[1]),
        .trig_seen(trig_seen[1]), .capture_done(capture_done[1]));

    always @(posedge clk) begin
        hist[cyc] <= probe_data;
        if (arm) arm_at <= cyc;
        cyc <= cyc + 1;
    end

    initial forever begin
        @(posedge clk); #1;
        case (mode)
            0: probe_data = held_val;
            1: begin probe_data = cnt_val; cnt_val = cnt_val + 8'd1; end
            default: probe_data = 8'($urandom);
        endcase
        rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Reference: the sample the trigger logic sees at cycle t is the probe from d cycles earlier.
    function automatic logic [7:0] s_at(int t, int d);
        return (t - d >= 0) ? hist[t-d] : 8'h00;
    endfunction

    function automatic logic match_at(int t, int d);
        return ((s_at(t, d) ^ trig_value) & trig_mask) == 8'h00;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_window(int d);
        int tt = -1;
        int p = int'(pre_len);
        logic [8:0] e;
        for (int t = arm_at + p + 1; t < cyc && tt < 0; t++)
            if (match_at(t, d) && (!trig_edge || !match_at(t - 1, d))) tt = t;
        if (tt < 0) begin
            compared++; mismatched++;
            $display("FAIL model_trigger pipe%0d: no hit found, expected one before capture_done", d);
            return;
        end
        for (int k = 0; k < 16; k++) begin
            e = {(k == 15), s_at(tt - p + k, d)};
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic do_abort();
        @(posedge clk); #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
    endtask

    task automatic start_capture(int p, logic [7:0] m, logic [7:0] v, logic e, int md);
        @(posedge clk); #2;
        trig_mask = m; trig_value = v; trig_edge = e; pre_len = 4'(p);
        mode = md; cnt_val = 8'd0;
        @(posedge clk); #2 arm = 1'b1;
        @(posedge clk); #2 arm = 1'b0;
    endtask

    task automatic finish_capture(logic rnd);
        int i;
        for (i = 0; i < 600 && !(capture_done[0] && capture_done[1]); i++) @(negedge clk);
        compared++;
        if (!(capture_done[0] && capture_done[1])) begin
            mismatched++;
            $display("FAIL capture_timeout: done=%0b%0b expected 11", capture_done[1], capture_done[0]);
            do_abort();
            return;
        end
        chk("trig_seen0", 32'(trig_seen[0]), 32'd1);
        chk("trig_seen2", 32'(trig_seen[1]), 32'd1);
        expect_window(0);
        expect_window(2);
        rnd_ready = rnd;
        @(posedge clk); #2 rd_start = 1'b1;
        @(posedge clk); #2 rd_start = 1'b0;
        for (i = 0; i < 600 && !(q0.size() == 0 && q1.size() == 0 &&
                                 capture_done[0] && capture_done[1]); i++) @(negedge clk);
        chk("beats_left0", 32'(q0.size()), 32'd0);
        chk("beats_left2", 32'(q1.size()), 32'd0);
        chk("done_after_read", {31'd0, capture_done[0] & capture_done[1]}, 32'd1);
        if (q0.size() != 0 || q1.size() != 0) begin
            do_abort();
            q0.delete(); q1.delete();
        end
        rnd_ready = 1'b0;
    endtask

    task automatic chk_idle(string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_busy"}, 32'(busy[k]), 32'd0);
            chk({tag, "_trig_seen"}, 32'(trig_seen[k]), 32'd0);
            chk({tag, "_capture_done"}, 32'(capture_done[k]), 32'd0);
            chk({tag, "_rd_valid"}, 32'(rd_valid[k]), 32'd0);
        end
    endtask

    initial begin
        logic [8:0] e;
        logic       ps [2];
        logic [8:0] pv [2];
        ps[0] = 1'b0; ps[1] = 1'b0;
        pv[0] = '0;   pv[1] = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    ps[k] = 1'b0;
                end else begin
                    if (ps[k]) begin
                        compared++;
                        if (!(rd_valid[k] && {rd_last[k], rd_data[k]} === pv[k])) begin
                            mismatched++;
                            $display("FAIL stall_hold dut%0d: got valid=%0b beat=%0h expected held %0h",
                                     k, rd_valid[k], {rd_last[k], rd_data[k]}, pv[k]);
                        end
                    end
                    if (rd_valid[k] && rd_ready) begin
                        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                            compared++; mismatched++;
                            $display("FAIL extra_beat dut%0d: got %0h expected none",
                                     k, {rd_last[k], rd_data[k]});
                        end else begin
                            if (k == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            compared++;
                            if ({rd_last[k], rd_data[k]} !== e) begin
                                mismatched++;
                                $display("FAIL beat dut%0d: got last=%0b data=%0h expected last=%0b data=%0h",
                                         k, rd_last[k], rd_data[k], e[8], e[7:0]);
                            end
                        end
                    end
                    ps[k] = rd_valid[k] && !rd_ready;
                    pv[k] = {rd_last[k], rd_data[k]};
                end
            end
        end
    end

    initial begin
        int i;
        logic [7:0] m;
        logic       ed;
        repeat (4) @(negedge clk);
        chk_idle("reset");
        chk("reset_rd_data0", 32'(rd_data[0]), 32'd0);
        chk("reset_rd_data2", 32'(rd_data[1]), 32'd0);
        chk("reset_rd_last0", 32'(rd_last[0]), 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Counter probe, level trigger on 10: window 6..21 with rd_last on 21.
        start_capture(4, 8'hFF, 8'd10, 1'b0, 1);
        finish_capture(1'b0);
        start_capture(4, 8'hFF, 8'd10, 1'b0, 1);
        finish_capture(1'b1);

        // Edge trigger: held at 10 through arm, then 10->11->10.
        held_val = 8'd10;
        start_capture(4, 8'hFF, 8'd10, 1'b1, 0);
        repeat (8) @(posedge clk);
        #2 held_val = 8'd11;
        repeat (2) @(posedge clk);
        #2 held_val = 8'd10;
        finish_capture(1'b1);

        start_capture(0, 8'hFF, 8'd10, 1'b0, 1);
        finish_capture(1'b1);
        start_capture(15, 8'hFF, 8'd20, 1'b0, 1);
        finish_capture(1'b0);

        // Abort while ARMED on a value that never appears.
        held_val = 8'd0;
        start_capture(3, 8'hFF, 8'd10, 1'b0, 0);
        repeat (8) @(negedge clk);
        chk("armed_busy0", 32'(busy[0]), 32'd1);
        chk("armed_busy2", 32'(busy[1]), 32'd1);
        do_abort();
        @(negedge clk);
        chk_idle("abort");
        start_capture(3, 8'hFF, 8'd10, 1'b0, 1);
        finish_capture(1'b1);

        // Reset while the pipe-0 instance is in POST.
        start_capture(2, 8'hFF, 8'd10, 1'b0, 1);
        for (i = 0; i < 300 && !trig_seen[0]; i++) @(negedge clk);
        chk("post_reached", 32'(trig_seen[0]), 32'd1);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk_idle("rst_post");
        repeat (4) @(posedge clk);
        start_capture(5, 8'hFF, 8'd10, 1'b0, 1);
        finish_capture(1'b1);

        for (int r = 0; r < 8; r++) begin
            m  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            ed = 1'($urandom_range(0, 1));
            if (ed && m == 8'h00) m = 8'h01;
            start_capture($urandom_range(0, 15), m, 8'($urandom), ed, 2);
            finish_capture(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
